// File: rtl/seq_acc_mp.sv
// Bit-serial MAC sequencer: issues one bipolar bit-plane per cycle (LSB first),
// shift-accumulates per-column ADC results tagged through a latency pipeline,
// then requantizes (round-half-up, arithmetic shift, saturation) behind a
// valid/ready output.
module seq_acc_mp #(
  parameter int maxInputBits   = 8,
  parameter int inputElements  = 128,
  parameter int outputElements = 32,
  parameter int adcBits        = 4,
  parameter int outputBits     = 8,
  parameter int adcLatency     = 1
) (
  input  logic                                            clk,
  input  logic                                            nrst,
  input  logic [$clog2(maxInputBits+1)-1:0]               cfg_in_bits_i,
  input  logic                                            cfg_signed_i,
  input  logic [$clog2(adcBits+maxInputBits+1)-1:0]       cfg_out_shift_i,
  input  logic [inputElements*maxInputBits-1:0]           mac_data_i,
  input  logic                                            mac_valid_i,
  output logic                                            mac_ready_o,
  output logic                                            mac_en_o,
  output logic [inputElements-1:0]                        data_p_o,
  output logic [inputElements-1:0]                        data_n_o,
  input  logic [outputElements*adcBits-1:0]               adc_out_i,
  output logic [outputElements*outputBits-1:0]            mac_data_o,
  output logic                                            valid_o,
  input  logic                                            ready_i,
  output logic                                            busy_o
);

  localparam int ACCB = adcBits + maxInputBits + 1;
  localparam int IBW  = $clog2(maxInputBits + 1);
  localparam int SHW  = $clog2(ACCB);
  localparam int KW   = (maxInputBits > 1) ? $clog2(maxInputBits) : 1;
  // Wide enough for the accumulator plus the largest rounding constant.
  localparam int RQW  = ACCB + (1 << SHW) + 1;
  localparam int OMAX_I = (1 << (outputBits - 1)) - 1;
  localparam int OMIN_I = -(1 << (outputBits - 1));
  localparam logic signed [RQW-1:0] OMAX = RQW'(OMAX_I);
  localparam logic signed [RQW-1:0] OMIN = RQW'(OMIN_I);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                                  state_q, state_d;
  logic [IBW-1:0]                          k_q, k_d;
  logic [IBW-1:0]                          ne_q, ne_d;
  logic                                    sgn_q, sgn_d;
  logic [SHW-1:0]                          shift_q, shift_d;
  logic [inputElements*maxInputBits-1:0]   data_q, data_d;
  logic                                    mac_ready_q, mac_ready_d;
  logic                                    mac_en_q, mac_en_d;
  logic [inputElements-1:0]                p_q, p_d, n_q, n_d;
  logic                                    valid_q, valid_d;
  logic [outputElements*outputBits-1:0]    mac_data_q, mac_data_d;
  logic signed [ACCB-1:0]                  acc_q [outputElements];
  logic signed [ACCB-1:0]                  acc_d [outputElements];
  logic signed [ACCB-1:0]                  acc_sum [outputElements];
  logic                                    tag_v_q [adcLatency];
  logic                                    tag_v_d [adcLatency];
  logic [IBW-1:0]                          tag_k_q [adcLatency];
  logic [IBW-1:0]                          tag_k_d [adcLatency];
  logic                                    tag_out_v;
  logic [IBW-1:0]                          tag_out_k;

  function automatic logic [IBW-1:0] eff_bits(input logic [IBW-1:0] b);
    if (b == '0) return IBW'(1);
    else if (b > IBW'(maxInputBits)) return IBW'(maxInputBits);
    else return b;
  endfunction

  // Returns {data_p, data_n} for plane k; the sign plane drives negative.
  function automatic logic [2*inputElements-1:0] make_plane(
    input logic [inputElements*maxInputBits-1:0] data,
    input logic [IBW-1:0] k,
    input logic [IBW-1:0] ne,
    input logic sgn
  );
    logic [inputElements-1:0] p, n;
    logic [maxInputBits-1:0]  elem;
    logic                     msb, b;
    msb = sgn && (k == ne - IBW'(1));
    for (int unsigned i = 0; i < inputElements; i++) begin
      elem = data[i*maxInputBits +: maxInputBits];
      b    = elem[k[KW-1:0]];
      p[i] = b && !msb;
      n[i] = b && msb;
    end
    return {p, n};
  endfunction

  function automatic logic [outputBits-1:0] requant(
    input logic signed [ACCB-1:0] a,
    input logic [SHW-1:0] s
  );
    logic signed [RQW-1:0] x, r;
    x = {{(RQW-ACCB){a[ACCB-1]}}, a};
    r = (s == '0) ? '0 : (RQW'(1) << (s - SHW'(1)));
    x = (x + r) >>> s;
    if (x > OMAX) x = OMAX;
    else if (x < OMIN) x = OMIN;
    return x[outputBits-1:0];
  endfunction

  assign tag_out_v = tag_v_q[adcLatency-1];
  assign tag_out_k = tag_k_q[adcLatency-1];

  // Per-column accumulator plus the emerging ADC result shifted by its plane weight.
  always_comb begin
    for (int unsigned c = 0; c < outputElements; c++) begin
      acc_sum[c] = acc_q[c] +
                   (ACCB'(signed'(adc_out_i[c*adcBits +: adcBits])) <<< tag_out_k);
    end
  end

  // Next-state logic for the sequencer, tag pipeline and accumulators.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ne_d        = ne_q;
    sgn_d       = sgn_q;
    shift_d     = shift_q;
    data_d      = data_q;
    mac_ready_d = mac_ready_q;
    mac_en_d    = mac_en_q;
    p_d         = p_q;
    n_d         = n_q;
    valid_d     = valid_q;
    mac_data_d  = mac_data_q;
    acc_d       = acc_q;
    if (tag_out_v) acc_d = acc_sum;

    tag_v_d[0] = mac_en_q;
    tag_k_d[0] = k_q;
    for (int unsigned j = 1; j < adcLatency; j++) begin
      tag_v_d[j] = tag_v_q[j-1];
      tag_k_d[j] = tag_k_q[j-1];
    end

    unique case (state_q)
      IDLE: begin
        if (mac_valid_i && mac_ready_q) begin
          // Plane 0 is driven straight from the inputs on the accept edge.
          data_d      = mac_data_i;
          ne_d        = eff_bits(cfg_in_bits_i);
          sgn_d       = cfg_signed_i;
          shift_d     = cfg_out_shift_i;
          acc_d       = '{default: '0};
          k_d         = '0;
          mac_en_d    = 1'b1;
          {p_d, n_d}  = make_plane(mac_data_i, '0, eff_bits(cfg_in_bits_i), cfg_signed_i);
          mac_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (k_q == ne_q - IBW'(1)) begin
          mac_en_d = 1'b0;
          p_d      = '0;
          n_d      = '0;
          state_d  = DRAIN;
        end else begin
          k_d        = k_q + IBW'(1);
          {p_d, n_d} = make_plane(data_q, k_q + IBW'(1), ne_q, sgn_q);
        end
      end
      DRAIN: begin
        // The final accumulation and requantization share one edge.
        if (tag_out_v && (tag_out_k == ne_q - IBW'(1))) begin
          for (int unsigned c = 0; c < outputElements; c++) begin
            mac_data_d[c*outputBits +: outputBits] = requant(acc_sum[c], shift_q);
          end
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (ready_i) begin
          valid_d     = 1'b0;
          mac_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ne_q        <= IBW'(1);
      sgn_q       <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      mac_ready_q <= 1'b1;
      mac_en_q    <= 1'b0;
      p_q         <= '0;
      n_q         <= '0;
      valid_q     <= 1'b0;
      mac_data_q  <= '0;
      acc_q       <= '{default: '0};
      tag_v_q     <= '{default: 1'b0};
      tag_k_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ne_q        <= ne_d;
      sgn_q       <= sgn_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      mac_ready_q <= mac_ready_d;
      mac_en_q    <= mac_en_d;
      p_q         <= p_d;
      n_q         <= n_d;
      valid_q     <= valid_d;
      mac_data_q  <= mac_data_d;
      acc_q       <= acc_d;
      tag_v_q     <= tag_v_d;
      tag_k_q     <= tag_k_d;
    end
  end

  assign mac_ready_o = mac_ready_q;
  assign mac_en_o    = mac_en_q;
  assign data_p_o    = p_q;
  assign data_n_o    = n_q;
  assign valid_o     = valid_q;
  assign mac_data_o  = mac_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_acc_mp.sv
// Bench for seq_acc_mp: two instances (ADC latency 1 and 3) share stimulus; an
// ADC stub replays a per-plane/per-column table at the right latency and drives
// junk otherwise. Expectations come from integer arithmetic on the activations
// and the table.
module tb_seq_acc_mp;
  localparam int MIB  = 8;
  localparam int NIN  = 128;
  localparam int NOUT = 32;
  localparam int ADCB = 4;
  localparam int OB   = 8;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [3:0]            cfg_bits_i;
  logic                  cfg_sgn_i;
  logic [3:0]            cfg_sh_i;
  logic [NIN*MIB-1:0]    mac_data;
  logic                  mac_valid, valid1, valid3;
  logic                  ready;
  logic [NOUT*ADCB-1:0]  adc;
  logic                  rdy1, en1, v1, busy1, rdy3, en3, v3, busy3;
  logic [NIN-1:0]        p1, n1, p3, n3;
  logic [NOUT*OB-1:0]    md1, md3;
  logic                  sel;
  logic                  o_ready, o_en, o_valid, o_busy;
  logic [NIN-1:0]        o_p, o_n;
  logic [NOUT*OB-1:0]    o_md;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NIN*MIB-1:0] act;
  int                 cfg_bits;
  bit                 sgn;
  int                 sh;
  int                 adc_tab [MIB][NOUT];
  bit [MIB-1:0]       p0v, n0v;

  always #5 clk = ~clk;

  assign valid1  = mac_valid && !sel;
  assign valid3  = mac_valid && sel;
  assign o_ready = sel ? rdy3  : rdy1;
  assign o_en    = sel ? en3   : en1;
  assign o_valid = sel ? v3    : v1;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_p     = sel ? p3    : p1;
  assign o_n     = sel ? n3    : n1;
  assign o_md    = sel ? md3   : md1;

  seq_acc_mp #(.maxInputBits(MIB), .inputElements(NIN), .outputElements(NOUT),
               .adcBits(ADCB), .outputBits(OB), .adcLatency(LAT1)) u_dut1 (
    .clk(clk), .nrst(nrst), .cfg_in_bits_i(cfg_bits_i), .cfg_signed_i(cfg_sgn_i),
    .cfg_out_shift_i(cfg_sh_i), .mac_data_i(mac_data), .mac_valid_i(valid1),
    .mac_ready_o(rdy1), .mac_en_o(en1), .data_p_o(p1), .data_n_o(n1),
    .adc_out_i(adc), .mac_data_o(md1), .valid_o(v1), .ready_i(ready), .busy_o(busy1));

  seq_acc_mp #(.maxInputBits(MIB), .inputElements(NIN), .outputElements(NOUT),
               .adcBits(ADCB), .outputBits(OB), .adcLatency(LAT3)) u_dut3 (
    .clk(clk), .nrst(nrst), .cfg_in_bits_i(cfg_bits_i), .cfg_signed_i(cfg_sgn_i),
    .cfg_out_shift_i(cfg_sh_i), .mac_data_i(mac_data), .mac_valid_i(valid3),
    .mac_ready_o(rdy3), .mac_en_o(en3), .data_p_o(p3), .data_n_o(n3),
    .adc_out_i(adc), .mac_data_o(md3), .valid_o(v3), .ready_i(ready), .busy_o(busy3));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NIN*MIB-1:0] rand_vec();
    logic [NIN*MIB-1:0] v;
    for (int i = 0; i < NIN*MIB/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NOUT*ADCB-1:0] junk_adc();
    logic [NOUT*ADCB-1:0] v;
    for (int i = 0; i < NOUT*ADCB/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_adc_const(input int v);
    for (int k = 0; k < MIB; k++) for (int c = 0; c < NOUT; c++) adc_tab[k][c] = v;
  endtask

  task automatic set_adc_rand();
    for (int k = 0; k < MIB; k++)
      for (int c = 0; c < NOUT; c++) adc_tab[k][c] = int'($urandom_range(0, 15)) - 8;
  endtask

  function automatic int eff_ne(input int b);
    if (b == 0) return 1;
    if (b > MIB) return MIB;
    return b;
  endfunction

  // Weighted column sum, rounded shift and clamp, in plain integer arithmetic.
  function automatic longint exp_out(input int c, input int ne);
    longint a = 0;
    for (int k = 0; k < ne; k++) a += longint'(adc_tab[k][c]) * (longint'(1) << k);
    if (sh > 0) a = (a + (longint'(1) << (sh - 1))) >>> sh;
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  function automatic int exp_elem(input int i, input int ne);
    int u;
    u = int'(act[i*MIB +: MIB]) & ((1 << ne) - 1);
    if (sgn && ((u >> (ne - 1)) & 1) == 1) u -= (1 << ne);
    return u;
  endfunction

  function automatic int col_mism(input int ne);
    int m = 0;
    for (int c = 0; c < NOUT; c++)
      if (longint'($signed(o_md[c*OB +: OB])) != exp_out(c, ne)) m++;
    return m;
  endfunction

  // One full transaction; called at a negedge with the DUT idle.
  task automatic run_vec(input string nm, input bit bp);
    int ne, lat, n_planes, first_en, last_en, first_valid, bad_recon, bad_idle, bad_rdy, idx, cnt;
    int hist[$];
    int recon [NIN];
    bit any_n;
    ne = eff_ne(cfg_bits);
    lat = sel ? LAT3 : LAT1;
    n_planes = 0; first_en = -1; last_en = -1; first_valid = -1;
    bad_recon = 0; bad_idle = 0; bad_rdy = 0; any_n = 1'b0;
    p0v = '0; n0v = '0;
    for (int i = 0; i < NIN; i++) recon[i] = 0;
    cfg_bits_i = 4'(cfg_bits); cfg_sgn_i = sgn; cfg_sh_i = 4'(sh);
    mac_data = act; mac_valid = 1'b1; ready = !bp; adc = junk_adc();
    @(posedge clk);
    @(negedge clk);
    mac_valid = 1'b0; mac_data = rand_vec(); cfg_bits_i = 4'($urandom); cfg_sh_i = 4'($urandom);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (o_valid) begin first_valid = cyc; break; end
      if (o_ready) bad_rdy++;
      if (o_en) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        for (int i = 0; i < NIN; i++)
          recon[i] += (int'(o_p[i]) - int'(o_n[i])) * (1 << (n_planes % 31));
        if (n_planes < MIB) begin p0v[n_planes] = o_p[0]; n0v[n_planes] = o_n[0]; end
        any_n |= |o_n;
        hist.push_back(n_planes);
        n_planes++;
      end else begin
        if (|o_p || |o_n) bad_idle++;
        hist.push_back(-1);
      end
      idx = cyc - lat;
      adc = junk_adc();
      if (idx >= 1 && hist[idx-1] >= 0 && hist[idx-1] < MIB)
        for (int c = 0; c < NOUT; c++) adc[c*ADCB +: ADCB] = 4'(adc_tab[hist[idx-1]][c]);
      @(negedge clk);
    end
    for (int i = 0; i < NIN; i++) if (recon[i] != exp_elem(i, ne)) bad_recon++;
    chk({nm, " valid_cycle"}, first_valid, ne + lat + 1);
    chk({nm, " planes"}, n_planes, ne);
    chk({nm, " first_en"}, first_en, 1);
    chk({nm, " last_en"}, last_en, ne);
    chk({nm, " plane_values_bad"}, bad_recon, 0);
    chk({nm, " drive_outside_issue"}, bad_idle, 0);
    chk({nm, " ready_while_busy"}, bad_rdy, 0);
    if (!sgn) chk({nm, " unsigned_neg_drive"}, any_n, 0);
    if (first_valid < 0) return;
    for (int c = 0; c < NOUT; c++)
      chk($sformatf("%s col%0d", nm, c), longint'($signed(o_md[c*OB +: OB])), exp_out(c, ne));
    if (bp) begin
      for (int t = 0; t < 5; t++) begin
        mac_valid = (t == 1 || t == 2);
        if (mac_valid) begin mac_data = rand_vec(); cfg_bits_i = 4'($urandom); end
        @(negedge clk);
        chk({nm, " bp_valid"}, o_valid, 1);
        chk({nm, " bp_ready"}, o_ready, 0);
        chk({nm, " bp_data_stable"}, col_mism(ne), 0);
      end
      ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, " post_valid"}, o_valid, 0);
    chk({nm, " post_ready"}, o_ready, 1);
    chk({nm, " post_busy"}, o_busy, 0);
    if (bp) begin
      cnt = 0;
      for (int t = 0; t < 3; t++) begin
        @(negedge clk);
        if (o_en || o_busy) cnt++;
      end
      chk({nm, " pulsed_vector_ignored"}, cnt, 0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " mac_ready"}, o_ready, 1);
    chk({nm, " valid"}, o_valid, 0);
    chk({nm, " mac_en"}, o_en, 0);
    chk({nm, " data_p_ones"}, $countones(o_p), 0);
    chk({nm, " data_n_ones"}, $countones(o_n), 0);
    chk({nm, " mac_data_ones"}, $countones(o_md), 0);
    chk({nm, " busy"}, o_busy, 0);
  endtask

  initial begin
    sel = 1'b0; nrst = 1'b0; ready = 1'b1; mac_valid = 1'b0;
    cfg_bits_i = '0; cfg_sgn_i = 1'b0; cfg_sh_i = '0; mac_data = '0; adc = junk_adc();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset1");
    sel = 1'b1;
    chk_reset_vals("reset3");
    sel = 1'b0;
    nrst = 1'b1;
    @(negedge clk);

    // Signed Ne=4, ADC +1 everywhere: 1+2+4+8 = 15 per column.
    act = rand_vec(); act[MIB-1:0] = 8'b0000_1010;
    cfg_bits = 4; sgn = 1'b1; sh = 0; set_adc_const(1);
    run_vec("t1_signed4", 1'b0);
    chk("t2_signed_p0", p0v, 8'b0000_0010);
    chk("t2_signed_n0", n0v, 8'b0000_1000);
    sgn = 1'b0;
    run_vec("t2_unsigned4", 1'b0);
    chk("t2_unsigned_p0", p0v, 8'b0000_1010);
    chk("t2_unsigned_n0", n0v, 8'b0000_0000);

    // Saturation and rounding on full-precision sums.
    act = rand_vec(); cfg_bits = 8; sgn = 1'b1;
    set_adc_const(7);  sh = 0; run_vec("t3_pos_s0", 1'b0);
    sh = 4; run_vec("t3_pos_s4", 1'b0);
    set_adc_const(-8); sh = 3; run_vec("t4_neg_s3", 1'b0);
    sh = 5; run_vec("t4_neg_s5", 1'b0);

    // Backpressure with a vector pulsed during OUT.
    act = rand_vec(); cfg_bits = 5; sgn = 1'b1; sh = 2; set_adc_rand();
    run_vec("t5_backpressure", 1'b1);

    // Precision clamping; signed Ne=1 drives only the negative rail.
    act = rand_vec(); sgn = 1'b1; sh = 0; set_adc_rand();
    cfg_bits = 0;  run_vec("t6_bits0", 1'b0);
    cfg_bits = 15; run_vec("t6_bits15", 1'b0);

    // Randomised runs on both latencies.
    for (int r = 0; r < 12; r++) begin
      sel = r[0];
      act = rand_vec(); cfg_bits = $urandom_range(0, 15); sgn = 1'($urandom);
      sh = $urandom_range(0, 12); set_adc_rand();
      run_vec($sformatf("rand%0d", r), 1'($urandom_range(0, 3) == 0));
    end

    // Reset during plane 2 of a latency-3 run, then an immediate short run.
    sel = 1'b1;
    act = rand_vec(); cfg_bits = 2; sgn = 1'b0; sh = 0; set_adc_const(3);
    run_vec("t6_pre_reset", 1'b0);
    act = rand_vec(); cfg_bits = 8; sgn = 1'b1; sh = 0; set_adc_const(7);
    cfg_bits_i = 4'(cfg_bits); cfg_sgn_i = sgn; cfg_sh_i = '0; mac_data = act; mac_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mac_valid = 1'b0; adc = junk_adc();
    @(negedge clk);
    adc = junk_adc();
    @(negedge clk);
    chk("t6_midrun_en", o_en, 1);
    nrst = 1'b0; adc = junk_adc();
    @(negedge clk);
    chk_reset_vals("t6_midrun_reset");
    nrst = 1'b1;
    act = rand_vec(); cfg_bits = 2; sgn = 1'b1; sh = 1; set_adc_rand();
    run_vec("t6_after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
